wave_display_reader: RTL and testbench

Read side of the double-buffered waveform RAM. While the raster scans the waveform window, it fetches 256 stored 8-bit samples from the RAM half selected by `read_index` and draws a connected trace. Outside that window it reports `wave_display_idle`, so the capture side can flip buffers without tearing. It sits between the 512×8 sample RAM and the VGA pixel mux.

---
 rtl/wave_display_reader.sv | 133 +++++++++++++
 tb/tb_wave_display_reader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_display_reader.sv
// wave_display_reader: read side of the double-buffered waveform RAM.
// Fetches 256 8-bit samples across a 512x256 pixel window and draws a
// connected trace; reports idle outside the window rows so the capture side
// can flip buffers without tearing. Fixed two-cycle pixel latency.
module wave_display_reader #(
    parameter int X_START = 64,
    parameter int Y_START = 112
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        read_index,
    output logic [8:0]  read_address,
    input  logic [7:0]  read_value,
    output logic        wave_display_idle,
    output logic        pixel_valid,
    output logic        pixel_on
);

    localparam logic [10:0] XS = 11'(X_START);
    localparam logic [10:0] XE = 11'(X_START + 512);
    localparam logic [9:0]  YS = 10'(Y_START);
    localparam logic [9:0]  YE = 10'(Y_START + 256);

    typedef enum logic {
        S_IDLE,
        S_DRAWING
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_rd_half;

    logic        w_in_cols;
    logic        w_in_rows;
    logic        w_in_win;
    logic [7:0]  w_idx;

    logic        r_in_win1;
    logic        r_valid1;
    logic [9:0]  r_y1;
    logic [7:0]  r_idx1;
    logic        r_odd1;
    logic [7:0]  r_prev;

    logic [7:0]  w_cur;
    logic [7:0]  w_prev;
    logic [7:0]  w_lo;
    logic [7:0]  w_hi;
    logic [7:0]  w_row;

    // Window test and RAM address for the current raster position.
    always_comb begin
        w_in_cols    = (x >= XS) && (x < XE);
        w_in_rows    = (y >= YS) && (y < YE);
        w_in_win     = valid && w_in_cols && w_in_rows;
        w_idx        = w_in_cols ? 8'((x - XS) >> 1) : '0;
        read_address = {r_rd_half, w_idx};
    end

    // Next-state logic: enter on the first visible in-row pixel, leave below the window or above it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (valid && w_in_rows)
                    w_next = S_DRAWING;
            end
            S_DRAWING: begin
                if ((valid && (y >= YE)) || (y < YS))
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register; the buffer half is latched only when a frame starts drawing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= S_IDLE;
            r_rd_half         <= 1'b0;
            wave_display_idle <= 1'b1;
        end else begin
            r_state           <= w_next;
            if ((r_state == S_IDLE) && (w_next == S_DRAWING))
                r_rd_half <= read_index;
            wave_display_idle <= (w_next == S_IDLE);
        end
    end

    // Stage 1: align pixel context with the RAM data; remember the last sample of each pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_win1 <= 1'b0;
            r_valid1  <= 1'b0;
            r_y1      <= '0;
            r_idx1    <= '0;
            r_odd1    <= 1'b0;
            r_prev    <= '0;
        end else begin
            r_in_win1 <= w_in_win;
            r_valid1  <= valid;
            r_y1      <= y;
            r_idx1    <= w_idx;
            r_odd1    <= x[0] ^ XS[0];
            if (r_in_win1 && r_odd1)
                r_prev <= read_value;
        end
    end

    // Segment bounds between previous and current sample, and the row value of this line.
    always_comb begin
        w_cur  = read_value;
        w_prev = (r_idx1 == '0) ? w_cur : r_prev;
        w_lo   = (w_prev < w_cur) ? w_prev : w_cur;
        w_hi   = (w_prev < w_cur) ? w_cur : w_prev;
        w_row  = 8'd255 - 8'(r_y1 - YS);
    end

    // Stage 2: registered pixel outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_on    <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_on    <= r_in_win1 && (w_row >= w_lo) && (w_row <= w_hi);
            pixel_valid <= r_valid1;
        end
    end

endmodule

// File: tb/tb_wave_display_reader.sv
// Self-checking bench for wave_display_reader: a behavioural RAM, a frame-level
// model that predicts each pixel from the stored samples, and scoreboard queues
// holding expected outputs until the DUT latency has elapsed.
module tb_wave_display_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = '0;
    logic [9:0]  y = '0;
    logic        valid = 1'b0;
    logic        read_index = 1'b0;
    logic [8:0]  read_address;
    logic [7:0]  read_value = '0;
    logic        wave_display_idle;
    logic        pixel_valid;
    logic        pixel_on;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:511];

    typedef struct {
        logic on;
        logic pv;
        int   px;
        int   py;
    } pix_t;

    pix_t q_pix[$];
    logic q_idle[$];
    logic m_draw;
    logic m_half;

    wave_display_reader #(.X_START(64), .Y_START(112)) dut (
        .clk               (clk),
        .reset             (reset),
        .x                 (x),
        .y                 (y),
        .valid             (valid),
        .read_index        (read_index),
        .read_address      (read_address),
        .read_value        (read_value),
        .wave_display_idle (wave_display_idle),
        .pixel_valid       (pixel_valid),
        .pixel_on          (pixel_on)
    );

    always #5 clk = ~clk;

    // Synchronous-read sample RAM
    always @(posedge clk) read_value <= mem[read_address];

    task automatic chk(input string tag, input int px, input int py,
                       input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s x=%0d y=%0d got=%0h exp=%0h", tag, px, py, got, exp);
        end
    endtask

    // Trace coverage from the stored samples of half h
    function automatic logic exp_on(input int xx, input int yy, input logic v, input logic h);
        int i, cur, prv, row, lo, hi;
        if (!v || xx < 64 || xx >= 576 || yy < 112 || yy >= 368) return 1'b0;
        i   = (xx - 64) / 2;
        cur = int'(mem[int'(h) * 256 + i]);
        prv = (i == 0) ? cur : int'(mem[int'(h) * 256 + i - 1]);
        row = 367 - yy;
        lo  = (prv < cur) ? prv : cur;
        hi  = (prv < cur) ? cur : prv;
        return (row >= lo) && (row <= hi);
    endfunction

    task automatic step(input int xx, input int yy, input logic v);
        pix_t e;
        logic h0;
        logic ie;
        int   idx;
        @(negedge clk);
        if (q_pix.size() == 2) begin
            e = q_pix.pop_front();
            chk("pixel_on", e.px, e.py, 16'(pixel_on), 16'(e.on));
            chk("pixel_valid", e.px, e.py, 16'(pixel_valid), 16'(e.pv));
        end
        if (q_idle.size() == 1) begin
            ie = q_idle.pop_front();
            chk("idle", xx, yy, 16'(wave_display_idle), 16'(ie));
        end
        x     = 11'(xx);
        y     = 10'(yy);
        valid = v;
        h0    = m_half;
        idx   = (xx >= 64 && xx < 576) ? (xx - 64) / 2 : 0;
        #1;
        chk("read_address", xx, yy, 16'(read_address), 16'(int'(h0) * 256 + idx));
        e.on = exp_on(xx, yy, v, h0);
        e.pv = v;
        e.px = xx;
        e.py = yy;
        q_pix.push_back(e);
        if (!m_draw) begin
            if (v && yy >= 112 && yy < 368) begin
                m_draw = 1'b1;
                m_half = read_index;
            end
        end else if ((v && yy >= 368) || yy < 112) begin
            m_draw = 1'b0;
        end
        q_idle.push_back(!m_draw);
    endtask

    task automatic do_reset();
        pix_t z;
        #2 reset = 1'b0;
        #1;
        chk("rst_idle", int'(x), int'(y), 16'(wave_display_idle), 16'd1);
        chk("rst_pixel_on", int'(x), int'(y), 16'(pixel_on), 16'd0);
        chk("rst_pixel_valid", int'(x), int'(y), 16'(pixel_valid), 16'd0);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        q_pix.delete();
        q_idle.delete();
        m_draw = 1'b0;
        m_half = 1'b0;
        z.on = 1'b0;
        z.pv = 1'b0;
        z.px = -1;
        z.py = -1;
        q_pix.push_back(z);
        q_pix.push_back(z);
        q_idle.push_back(1'b1);
    endtask

    task automatic scan_row(input int yy);
        for (int xx = 60; xx <= 579; xx++) step(xx, yy, 1'b1);
    endtask

    task automatic fill(input int half, input logic [7:0] val);
        for (int i = 0; i < 256; i++) mem[half * 256 + i] = val;
    endtask

    initial begin
        m_draw = 1'b0;
        m_half = 1'b0;
        fill(0, 8'd128);
        fill(1, 8'd128);
        do_reset();

        // Flat trace at 128: only row Y_START+127 lit
        step(0, 100, 1'b1);
        scan_row(239);
        scan_row(238);
        scan_row(240);

        // valid low inside the window
        step(100, 239, 1'b0);
        step(101, 239, 1'b0);

        // Step between samples 9 and 10
        mem[9]  = 8'd100;
        mem[10] = 8'd200;
        scan_row(167);
        scan_row(200);
        scan_row(267);
        scan_row(166);
        scan_row(268);
        scan_row(239);
        mem[9]  = 8'd128;
        mem[10] = 8'd128;

        // Extreme samples at both ends, and pixels just outside the rows
        mem[0]   = 8'd0;
        mem[255] = 8'd255;
        scan_row(367);
        scan_row(112);
        step(64, 111, 1'b1);
        step(70, 368, 1'b1);
        step(575, 368, 1'b1);
        mem[0]   = 8'd128;
        mem[255] = 8'd128;

        // Handshake over a whole frame of rows
        for (int yy = 100; yy <= 380; yy++) begin
            step(0, yy, 1'b1);
            step(600, yy, 1'b1);
        end

        // Buffer select: toggle while drawing is ignored until the next frame
        fill(0, 8'd50);
        fill(1, 8'd220);
        read_index = 1'b0;
        step(0, 380, 1'b1);
        scan_row(317);
        read_index = 1'b1;
        scan_row(317);
        scan_row(147);
        step(0, 370, 1'b1);
        scan_row(147);
        scan_row(317);

        // read_index changes on the same cycle the frame starts
        step(0, 380, 1'b1);
        read_index = 1'b0;
        scan_row(317);

        // Reset mid-frame, then re-latch the new read_index
        read_index = 1'b1;
        for (int xx = 60; xx <= 100; xx++) step(xx, 317, 1'b1);
        do_reset();
        scan_row(147);

        // Drain the pipeline
        step(0, 0, 1'b0);
        step(0, 0, 1'b0);
        step(0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
